int_ctrl: RTL and testbench
===========================

# int_ctrl

Platform-level external interrupt controller for the npc core. It latches up to NUM_SRC external interrupt sources, applies per-source enable, priority and edge/level mode, and raises one machine external interrupt request toward the trap unit's int_i input. Software uses a word-addressed configuration port to configure it and to run the claim/complete handshake.

## Interface
Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..31; source IDs are 1..NUM_SRC, and ID 0 means none.
- PRIO_W, 3: priority width; priority 0 means the source never interrupts.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_i  in  NUM_SRC  raw asynchronous interrupt lines, active-high
- cfg_we_i  in  1  config write strobe
- cfg_re_i  in  1  config read strobe
- cfg_addr_i  in  6  word address
- cfg_wdata_i  in  32  write data
- cfg_rdata_o  out  32  read data, registered, valid the cycle after cfg_re_i
- int_o  out  1  external interrupt request to the trap unit, registered
- int_id_o  out  5  current best candidate ID, combinational, for debug

## Operation
- Synchronization: each src_i bit passes through a 2-flop synchronizer to give s[i].
- Register map (word addresses):
  - 0x00 ENABLE: RW, bits [NUM_SRC-1:0].
  - 0x01 THRESHOLD: RW, bits [PRIO_W-1:0].
  - 0x02 PENDING: RO.
  - 0x03 CLAIM: RW with side effects.
  - 0x04 EDGE: RW; 1 selects edge mode, 0 selects level mode.
  - 0x08+i PRIORITY of source i+1: RW.
  - Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.
- Pending set rules:
  - Edge mode: a rising edge of s[i] (registered previous value) sets pending.
  - Level mode: pending follows s[i] while the source is not in service.
  - Pending is tracked independently of ENABLE.
- Candidate selection: candidates are sources with pending, enable set, priority > THRESHOLD and not in service. The winner has the highest priority; ties go to the lowest ID. int_id_o is the winner's ID, or 0 if there are no candidates.
- int_o is the registered value of (int_id_o != 0).
- Claim (read of CLAIM): returns the winner's ID in cfg_rdata_o. The winner's pending bit is cleared and its in_service bit is set. A claim with no candidate returns 0 and has no side effect.
- Complete (write of CLAIM with an ID): clears in_service of that source. An ID of 0, an out-of-range ID, or an ID not in service is ignored.
- A source in service is never re-selected until it is completed.

## Timing
- Reset values: all registers 0, pending 0, in_service 0, int_o 0, cfg_rdata_o 0, synchronizer flops 0.
- src_i to int_o latency: src_i rises before edge N.
  - Edge N: sync1.
  - Edge N+1: s.
  - Edge N+2: pending.
  - Edge N+3: int_o = 1.
- Reads: the address is sampled at edge K. cfg_rdata_o is valid after edge K and holds until the next read. Claim side effects apply at edge K.
- Writes take effect at the sampling edge. int_o reflects any config change one edge later.
- Simultaneous cfg_we_i and cfg_re_i: both are performed. The read returns the pre-write value.
- Same-cycle edge event and claim of the same source: the set wins, so pending stays 1. The new event is served after completion.
- Same-cycle complete and a level source still high: pending is recaptured on the following edge.
- Lowering ENABLE or a priority, or raising THRESHOLD, drops int_o on the next edge. Pending is preserved.
- Reset asserted mid-operation clears all state asynchronously. Pending edges are lost.

## Structure
- Shared defines header gets:
  - the register address constants (INTC_ENABLE, INTC_THRESHOLD, INTC_PENDING, INTC_CLAIM, INTC_EDGE, INTC_PRIO_BASE);
  - the ID width constant;
  - the MEI cause value 32'h8000000B, used by the trap unit.
- One sub-module, int_prio_sel: a combinational priority/index reduction tree over NUM_SRC candidates that outputs the winning ID. The synchronizer, registers and handshake stay in int_ctrl.

## Test plan
- Reset, then configure: ENABLE=0x04, PRIORITY3=5, THRESHOLD=2, EDGE=0x04. Pulse src_i[2] for 1 cycle. int_o is required to rise exactly 4 edges later; a CLAIM read must return 3 and clear PENDING; int_o falls next edge.
- Sources 1 and 5 are both level-high with priorities 4 and 4. Claims are required to return 1, then 5 after completing 1. Completing 5 while src 5 is still high is required to re-raise int_o.
- Priority 2 with THRESHOLD=2: pending is required to be set and int_o must stay 0. Writing THRESHOLD=1 is required to raise int_o one edge after the write.
- An edge on source 3 in the same cycle as its claim: the claim is required to return 3 and PENDING bit 2 must remain 1. After completing, a second claim is required to return 3.
- A CLAIM read with nothing pending is required to return 0. A complete with ID 9 or with an unclaimed ID is required to leave in_service unchanged.
- Assert rst_n low mid-claim: all outputs are required to be 0 immediately and the registers to read 0 after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the platform external interrupt controller.
// Register word addresses, ID width and the MEI trap cause.
package int_ctrl_pkg;

    localparam int ID_W = 5;

    localparam logic [5:0] INTC_ENABLE    = 6'h00;
    localparam logic [5:0] INTC_THRESHOLD = 6'h01;
    localparam logic [5:0] INTC_PENDING   = 6'h02;
    localparam logic [5:0] INTC_CLAIM     = 6'h03;
    localparam logic [5:0] INTC_EDGE      = 6'h04;
    localparam logic [5:0] INTC_PRIO_BASE = 6'h08;

    localparam logic [31:0] MEI_CAUSE = 32'h8000000B;

endpackage

// File: rtl/int_ctrl_if.sv
// Word-addressed configuration port of the interrupt controller.
// Read data is registered and valid the cycle after the read strobe.
interface int_ctrl_if;

    logic        cfg_we_i;
    logic        cfg_re_i;
    logic [5:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic [31:0] cfg_rdata_o;

    modport master (
        output cfg_we_i,
        output cfg_re_i,
        output cfg_addr_i,
        output cfg_wdata_i,
        input  cfg_rdata_o
    );

    modport slave (
        input  cfg_we_i,
        input  cfg_re_i,
        input  cfg_addr_i,
        input  cfg_wdata_i,
        output cfg_rdata_o
    );

endinterface

// File: rtl/int_prio_sel.sv
// Combinational binary reduction tree picking the highest-priority
// candidate; ties resolve to the lowest source ID.
module int_prio_sel
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0]             cand_i,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]                id_o
);

    localparam int P = 1 << $clog2(NUM_SRC);

    logic              nd_vld  [2*P-1:1];
    logic [PRIO_W-1:0] nd_prio [2*P-1:1];
    logic [ID_W-1:0]   nd_id   [2*P-1:1];

    // Heap layout: leaves at P..2P-1, node n reduces 2n and 2n+1.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            nd_vld[P+i]  = 1'b0;
            nd_prio[P+i] = '0;
            nd_id[P+i]   = ID_W'(i + 1);
            if (i < NUM_SRC) begin
                nd_vld[P+i]  = cand_i[i];
                nd_prio[P+i] = prio_i[i];
            end
        end
        for (int n = P - 1; n >= 1; n--) begin
            // Left subtree holds lower IDs, so it keeps ties.
            if (nd_vld[2*n] &&
                (!nd_vld[2*n+1] ||
                 nd_prio[2*n] >= nd_prio[2*n+1])) begin
                nd_vld[n]  = 1'b1;
                nd_prio[n] = nd_prio[2*n];
                nd_id[n]   = nd_id[2*n];
            end else begin
                nd_vld[n]  = nd_vld[2*n+1];
                nd_prio[n] = nd_prio[2*n+1];
                nd_id[n]   = nd_id[2*n+1];
            end
        end
        id_o = nd_vld[1] ? nd_id[1] : '0;
    end

endmodule

// File: rtl/int_ctrl.sv
// Platform external interrupt controller: syncs sources, tracks
// pending/in-service and runs claim/complete toward the trap unit.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    int_ctrl_if.slave          cfg,
    output logic               int_o,
    output logic [ID_W-1:0]    int_id_o
);

    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] s_q, s_d;
    logic [NUM_SRC-1:0] s_prev_q, s_prev_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [PRIO_W-1:0]  threshold_q, threshold_d;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               int_q, int_d;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] cmp_hit;
    logic [ID_W-1:0]    win_id;
    logic               claim;
    logic               complete;
    logic [31:0]        rd;

    assign claim    = cfg.cfg_re_i && cfg.cfg_addr_i == INTC_CLAIM;
    assign complete = cfg.cfg_we_i && cfg.cfg_addr_i == INTC_CLAIM;
    assign rise     = s_q & ~s_prev_q;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i] = pending_q[i] && enable_q[i] &&
                      !in_service_q[i] &&
                      prio_q[i] > threshold_q;
            claim_hit[i] = claim && win_id == ID_W'(i + 1);
            cmp_hit[i]   = complete &&
                           cfg.cfg_wdata_i == 32'(i + 1);
        end
    end

    int_prio_sel #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_sel (
        .cand_i (cand),
        .prio_i (prio_q),
        .id_o   (win_id)
    );

    always_comb begin
        sync1_d      = src_i;
        s_d          = sync1_q;
        s_prev_d     = s_q;
        enable_d     = enable_q;
        edge_d       = edge_q;
        threshold_d  = threshold_q;
        prio_d       = prio_q;
        pending_d    = pending_q;
        in_service_d = in_service_q;
        int_d        = win_id != '0;

        for (int i = 0; i < NUM_SRC; i++) begin
            // A fresh edge beats a same-cycle claim.
            if (edge_q[i])
                pending_d[i] = (pending_q[i] & ~claim_hit[i])
                             | rise[i];
            else if (claim_hit[i])
                pending_d[i] = 1'b0;
            else if (!in_service_q[i])
                pending_d[i] = s_q[i];
            in_service_d[i] = (in_service_q[i] | claim_hit[i])
                            & ~cmp_hit[i];
        end

        if (cfg.cfg_we_i) begin
            unique case (1'b1)
                cfg.cfg_addr_i == INTC_ENABLE:
                    enable_d = cfg.cfg_wdata_i[NUM_SRC-1:0];
                cfg.cfg_addr_i == INTC_THRESHOLD:
                    threshold_d = cfg.cfg_wdata_i[PRIO_W-1:0];
                cfg.cfg_addr_i == INTC_EDGE:
                    edge_d = cfg.cfg_wdata_i[NUM_SRC-1:0];
                default: ;
            endcase
            for (int i = 0; i < NUM_SRC; i++)
                if (cfg.cfg_addr_i == INTC_PRIO_BASE + 6'(i))
                    prio_d[i] = cfg.cfg_wdata_i[PRIO_W-1:0];
        end
    end

    // Reads see pre-write state, so read-during-write returns old data.
    always_comb begin
        rd = '0;
        unique case (1'b1)
            cfg.cfg_addr_i == INTC_ENABLE:
                rd[NUM_SRC-1:0] = enable_q;
            cfg.cfg_addr_i == INTC_THRESHOLD:
                rd[PRIO_W-1:0] = threshold_q;
            cfg.cfg_addr_i == INTC_PENDING:
                rd[NUM_SRC-1:0] = pending_q;
            cfg.cfg_addr_i == INTC_CLAIM:
                rd[ID_W-1:0] = win_id;
            cfg.cfg_addr_i == INTC_EDGE:
                rd[NUM_SRC-1:0] = edge_q;
            default: ;
        endcase
        for (int i = 0; i < NUM_SRC; i++)
            if (cfg.cfg_addr_i == INTC_PRIO_BASE + 6'(i))
                rd[PRIO_W-1:0] = prio_q[i];
        rdata_d = cfg.cfg_re_i ? rd : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            s_q          <= '0;
            s_prev_q     <= '0;
            enable_q     <= '0;
            edge_q       <= '0;
            threshold_q  <= '0;
            prio_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            rdata_q      <= '0;
            int_q        <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            s_prev_q     <= s_prev_d;
            enable_q     <= enable_d;
            edge_q       <= edge_d;
            threshold_q  <= threshold_d;
            prio_q       <= prio_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            rdata_q      <= rdata_d;
            int_q        <= int_d;
        end
    end

    assign int_o           = int_q;
    assign int_id_o        = win_id;
    assign cfg.cfg_rdata_o = rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, claim/complete, thresholds,
// same-cycle edge/claim, bad completes and asynchronous reset.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  src = '0;
    logic        int_o;
    logic [4:0]  int_id;
    logic [31:0] d;
    int          checks = 0;
    int          errors = 0;

    int_ctrl_if cfg ();

    int_ctrl #(
        .NUM_SRC (8),
        .PRIO_W  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .src_i    (src),
        .cfg      (cfg),
        .int_o    (int_o),
        .int_id_o (int_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] v);
        @(negedge clk);
        cfg.cfg_we_i    = 1'b1;
        cfg.cfg_addr_i  = a;
        cfg.cfg_wdata_i = v;
        tick(1);
        cfg.cfg_we_i    = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        @(negedge clk);
        cfg.cfg_re_i   = 1'b1;
        cfg.cfg_addr_i = a;
        tick(1);
        cfg.cfg_re_i   = 1'b0;
        v = cfg.cfg_rdata_o;
    endtask

    task automatic rdwr(input logic [5:0] a, input logic [31:0] v,
                        output logic [31:0] r);
        @(negedge clk);
        cfg.cfg_we_i    = 1'b1;
        cfg.cfg_re_i    = 1'b1;
        cfg.cfg_addr_i  = a;
        cfg.cfg_wdata_i = v;
        tick(1);
        cfg.cfg_we_i    = 1'b0;
        cfg.cfg_re_i    = 1'b0;
        r = cfg.cfg_rdata_o;
    endtask

    task automatic pulse(input int b);
        @(negedge clk);
        src[b] = 1'b1;
        tick(1);
        src[b] = 1'b0;
    endtask

    initial begin
        cfg.cfg_we_i    = 1'b0;
        cfg.cfg_re_i    = 1'b0;
        cfg.cfg_addr_i  = '0;
        cfg.cfg_wdata_i = '0;
        tick(2);
        chk("rst_int", int_o, 0);
        chk("rst_id", int_id, 0);
        chk("rst_rdata", cfg.cfg_rdata_o, 0);
        @(negedge clk) rst_n = 1'b1;

        // Edge source 3: four-edge latency, claim, int_o falls.
        wr(INTC_ENABLE, 32'h04);
        wr(INTC_PRIO_BASE + 6'd2, 5);
        wr(INTC_THRESHOLD, 2);
        wr(INTC_EDGE, 32'h04);
        pulse(2);
        chk("lat_e0", int_o, 0);
        tick(1); chk("lat_e1", int_o, 0);
        tick(1); chk("lat_e2", int_o, 0);
        chk("lat_id", int_id, 3);
        tick(1); chk("lat_e3", int_o, 1);
        rd(INTC_PENDING, d); chk("t1_pend", d, 32'h04);
        rd(INTC_CLAIM, d); chk("t1_claim", d, 3);
        chk("t1_int_hold", int_o, 1);
        rd(INTC_PENDING, d); chk("t1_pend_clr", d, 0);
        chk("t1_int_fall", int_o, 0);
        wr(INTC_CLAIM, 3);

        // Level sources 1 and 5 at equal priority.
        wr(INTC_ENABLE, 32'h15);
        wr(INTC_PRIO_BASE + 6'd0, 4);
        wr(INTC_PRIO_BASE + 6'd4, 4);
        src[0] = 1'b1;
        src[4] = 1'b1;
        tick(4);
        chk("lvl_int", int_o, 1);
        chk("lvl_tie_id", int_id, 1);
        rd(INTC_CLAIM, d); chk("lvl_claim1", d, 1);
        src[0] = 1'b0;
        tick(3);
        wr(INTC_CLAIM, 1);
        rd(INTC_CLAIM, d); chk("lvl_claim5", d, 5);
        tick(1); chk("lvl_int_low", int_o, 0);
        wr(INTC_CLAIM, 5);
        chk("lvl_cmp_e0", int_o, 0);
        tick(1); chk("lvl_recap_id", int_id, 5);
        chk("lvl_cmp_e1", int_o, 0);
        tick(1); chk("lvl_reraise", int_o, 1);
        src[4] = 1'b0;
        wr(INTC_ENABLE, 32'h04);
        tick(3);
        rd(INTC_PENDING, d); chk("lvl_pend_drop", d, 0);

        // Priority equal to threshold never interrupts.
        wr(INTC_PRIO_BASE + 6'd1, 2);
        wr(INTC_ENABLE, 32'h06);
        src[1] = 1'b1;
        tick(4);
        rd(INTC_PENDING, d); chk("thr_pend", d, 32'h02);
        chk("thr_int_off", int_o, 0);
        chk("thr_id_off", int_id, 0);
        wr(INTC_THRESHOLD, 1);
        chk("thr_wr_e0", int_o, 0);
        tick(1); chk("thr_wr_e1", int_o, 1);
        chk("thr_id", int_id, 2);
        wr(INTC_ENABLE, 32'h04);
        chk("en_drop_e0", int_o, 1);
        tick(1); chk("en_drop_e1", int_o, 0);
        rd(INTC_PENDING, d); chk("en_pend_kept", d, 32'h02);
        wr(INTC_ENABLE, 32'h06);
        rd(INTC_CLAIM, d); chk("thr_claim", d, 2);
        wr(INTC_CLAIM, 9);
        wr(INTC_CLAIM, 4);
        tick(1); chk("bad_cmp_int", int_o, 0);
        rd(INTC_PENDING, d); chk("bad_cmp_pend", d, 0);
        wr(INTC_CLAIM, 2);
        tick(1); chk("cmp2_e1", int_o, 0);
        tick(1); chk("cmp2_e2", int_o, 1);
        src[1] = 1'b0;
        tick(4); chk("src2_low", int_o, 0);
        wr(INTC_THRESHOLD, 2);
        wr(INTC_ENABLE, 32'h04);
        rd(6'h05, d); chk("unmapped", d, 0);
        rd(INTC_PRIO_BASE + 6'd2, d); chk("prio3_rd", d, 5);
        rd(INTC_EDGE, d); chk("edge_rd", d, 32'h04);

        // New edge on source 3 in the claim cycle stays pending.
        pulse(2);
        tick(3); chk("sc_int", int_o, 1);
        pulse(2);
        tick(1);
        rd(INTC_CLAIM, d); chk("sc_claim", d, 3);
        rd(INTC_PENDING, d); chk("sc_pend", d, 32'h04);
        chk("sc_no_resel", int_o, 0);
        wr(INTC_CLAIM, 3);
        rd(INTC_CLAIM, d); chk("sc_claim2", d, 3);
        wr(INTC_CLAIM, 3);
        rd(INTC_CLAIM, d); chk("empty_claim", d, 0);

        rdwr(INTC_THRESHOLD, 3, d); chk("rw_old", d, 2);
        rd(INTC_THRESHOLD, d); chk("rw_new", d, 3);
        wr(INTC_THRESHOLD, 2);

        // Asynchronous reset in the middle of a claim.
        pulse(2);
        tick(3); chk("pre_rst_int", int_o, 1);
        rd(INTC_PENDING, d); chk("pre_rst_pend", d, 32'h04);
        @(negedge clk);
        cfg.cfg_re_i   = 1'b1;
        cfg.cfg_addr_i = INTC_CLAIM;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_int", int_o, 0);
        chk("arst_id", int_id, 0);
        chk("arst_rdata", cfg.cfg_rdata_o, 0);
        cfg.cfg_re_i = 1'b0;
        tick(2);
        @(negedge clk) rst_n = 1'b1;
        rd(INTC_ENABLE, d); chk("post_en", d, 0);
        rd(INTC_THRESHOLD, d); chk("post_thr", d, 0);
        rd(INTC_EDGE, d); chk("post_edge", d, 0);
        rd(INTC_PRIO_BASE + 6'd2, d); chk("post_prio", d, 0);
        rd(INTC_PENDING, d); chk("post_pend", d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
